// File: rtl/fp_sched_pkg.sv
// Shared types, FP32 constants and the round-robin pick helper for the
// FP adder scheduler.
package fp_sched_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ONE   = 32'h3F800000;
    localparam fp32_t FP_TWO   = 32'h40000000;
    localparam fp32_t FP_THREE = 32'h40400000;

    // Upper bound on requesters; rr_pick works on vectors of this width.
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First valid requester at or above ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [PTR_W-1:0]   ptr,
                                         input int                 nreq);
        rr_pick_t         res;
        int               pos;
        logic [PTR_W-1:0] posIdx;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            pos    = (int'(ptr) + i) % nreq;
            posIdx = PTR_W'(pos);
            if ((i < nreq) && !res.found && valid[posIdx]) begin
                res.found = 1'b1;
                res.idx   = posIdx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Requester, adder and result signals of the FP adder scheduler.
// The scheduler uses the slave view; the surrounding logic uses master.
interface fp_add_scheduler_if #(
    parameter int NREQ = 4
);
    import fp_sched_pkg::*;

    logic [NREQ-1:0]         iREQ_VALID;
    logic [NREQ*32-1:0]      iREQ_A;
    logic [NREQ*32-1:0]      iREQ_B;
    logic [NREQ-1:0]         iREQ_ADD;
    logic [NREQ-1:0]         oREQ_READY;
    logic                    iFLUSH;
    fp32_t                   oADD_A;
    fp32_t                   oADD_B;
    logic                    oADD_ADDSUB;
    fp32_t                   iADD_RESULT;
    logic                    oRES_VALID;
    logic [$clog2(NREQ)-1:0] oRES_TAG;
    fp32_t                   oRES_DATA;
    logic                    oIDLE;

    modport slave (
        input  iREQ_VALID, iREQ_A, iREQ_B, iREQ_ADD, iFLUSH, iADD_RESULT,
        output oREQ_READY, oADD_A, oADD_B, oADD_ADDSUB,
        output oRES_VALID, oRES_TAG, oRES_DATA, oIDLE
    );

    modport master (
        output iREQ_VALID, iREQ_A, iREQ_B, iREQ_ADD, iFLUSH, iADD_RESULT,
        input  oREQ_READY, oADD_A, oADD_B, oADD_ADDSUB,
        input  oRES_VALID, oRES_TAG, oRES_DATA, oIDLE
    );

endinterface

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the pointer upward, pointer moves
// past the winner after every handshake.
module rr_arbiter
    import fp_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_valid,
    input  logic                    i_block,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]   r_ptr;
    logic [MAX_REQ-1:0] w_valid_ext;
    rr_pick_t           w_pick;
    logic [NREQ-1:0]    w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_hs;

    // Pick the winner and expand it into a one-hot grant, suppressed while blocked.
    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = i_valid;
        w_pick                  = rr_pick(w_valid_ext, PTR_W'(r_ptr), NREQ);
        w_grant                 = '0;
        w_grant_idx             = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick.found && !i_block && (w_pick.idx == PTR_W'(k))) begin
                w_grant[k]  = 1'b1;
                w_grant_idx = IDX_W'(k);
            end
        end
    end

    assign w_hs        = |(i_valid & w_grant);
    assign o_grant     = w_grant;
    assign o_grant_idx = w_grant_idx;

    // Advance the pointer just past the requester that completed a handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_grant_idx == IDX_W'(NREQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one free-running pipelined FP32 adder among NREQ requesters.
// A tag pipe matched to the adder latency marks which adder outputs are real
// and who owns them; everything else coming out of the adder is ignored.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 7
) (
    input logic               iCLK,
    input logic               iRST_N,
    fp_add_scheduler_if.slave bus
);
    localparam int TAG_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(ADD_LAT + 2);

    logic [NREQ-1:0]              w_grant;
    logic [TAG_W-1:0]             w_grant_idx;
    logic                         w_block;
    logic                         w_hs;
    logic                         w_complete;
    fp32_t                        w_sel_a;
    fp32_t                        w_sel_b;
    logic                         w_sel_add;

    fp32_t                        r_add_a;
    fp32_t                        r_add_b;
    logic                         r_add_addsub;
    logic [ADD_LAT:0]             r_pipe_valid;
    logic [ADD_LAT:0][TAG_W-1:0]  r_pipe_tag;
    logic                         r_res_valid;
    logic [TAG_W-1:0]             r_res_tag;
    fp32_t                        r_res_data;
    logic [CNT_W-1:0]             r_inflight;

    // Reset is folded into the block so READY is forced low while held in reset.
    assign w_block = bus.iFLUSH | ~iRST_N;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk       (iCLK),
        .i_rst_n     (iRST_N),
        .i_valid     (bus.iREQ_VALID),
        .i_block     (w_block),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_hs       = |(bus.iREQ_VALID & w_grant);
    assign w_complete = r_pipe_valid[ADD_LAT];

    // Route the granted requester's operands toward the adder input registers.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_add = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a   = bus.iREQ_A[32*k +: 32];
                w_sel_b   = bus.iREQ_B[32*k +: 32];
                w_sel_add = bus.iREQ_ADD[k];
            end
        end
    end

    // Adder operand registers only load on a handshake and otherwise hold.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_addsub <= 1'b1;
        end else if (w_hs) begin
            r_add_a      <= w_sel_a;
            r_add_b      <= w_sel_b;
            r_add_addsub <= w_sel_add;
        end
    end

    // Tag pipe shadows the adder: stage 0 is loaded with this edge's handshake.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pipe_valid <= '0;
            r_pipe_tag   <= '0;
        end else begin
            r_pipe_valid <= {r_pipe_valid[ADD_LAT-1:0], w_hs};
            r_pipe_tag   <= {r_pipe_tag[ADD_LAT-1:0], w_grant_idx};
        end
    end

    // Capture the adder result on the edge where its tag leaves the pipe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= w_complete;
            if (w_complete) begin
                r_res_tag  <= r_pipe_tag[ADD_LAT];
                r_res_data <= bus.iADD_RESULT;
            end
        end
    end

    // In-flight count: up on issue, down as a result is captured, hold if both.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_inflight <= '0;
        end else begin
            case ({w_hs, w_complete})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.oREQ_READY  = w_grant;
    assign bus.oADD_A      = r_add_a;
    assign bus.oADD_B      = r_add_b;
    assign bus.oADD_ADDSUB = r_add_addsub;
    assign bus.oRES_VALID  = r_res_valid;
    assign bus.oRES_TAG    = r_res_tag;
    assign bus.oRES_DATA   = r_res_data;
    assign bus.oIDLE       = (r_inflight == '0) && (w_grant == '0);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a table-driven ADD_LAT-deep adder model.
module tb_fp_add_scheduler;
    import fp_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int ADD_LAT = 7;

    logic  iCLK   = 1'b0;
    logic  iRST_N = 1'b0;
    int    nChecks = 0;
    int    nPass   = 0;
    int    nFail   = 0;
    int    cyc     = 0;
    int    issueCyc;
    int    rTag;
    int    rCyc;
    int    firstCyc;
    fp32_t rData;
    fp32_t mdlPipe [ADD_LAT];
    fp32_t exp2 [4];

    int    resTagQ[$];
    fp32_t resDataQ[$];
    int    resCycQ[$];

    fp_add_scheduler_if #(.NREQ(NREQ)) bus ();

    fp_add_scheduler #(
        .NREQ    (NREQ),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 iCLK = ~iCLK;

    // Cycle counter used to time-stamp issues and results.
    always @(posedge iCLK) cyc <= cyc + 1;

    // Hand-computed FP32 sums for the operand pairs the bench uses.
    function automatic fp32_t fpModel(input fp32_t a, input fp32_t b, input logic isAdd);
        if (isAdd) begin
            if (a == FP_ONE   && b == FP_TWO)   return 32'h40400000;
            if (a == FP_TWO   && b == FP_TWO)   return 32'h40800000;
            if (a == FP_THREE && b == FP_THREE) return 32'h40C00000;
            if (a == FP_ONE   && b == FP_ONE)   return 32'h40000000;
        end else begin
            if (a == FP_TWO   && b == FP_ONE)   return 32'h3F800000;
            if (a == FP_THREE && b == FP_ONE)   return 32'h40000000;
        end
        return 32'hDEADBEEF;
    endfunction

    // Behavioural adder: result appears ADD_LAT edges after operands are presented.
    always @(posedge iCLK) begin
        mdlPipe[0] <= fpModel(bus.oADD_A, bus.oADD_B, bus.oADD_ADDSUB);
        for (int k = 1; k < ADD_LAT; k++) mdlPipe[k] <= mdlPipe[k-1];
    end
    assign bus.iADD_RESULT = mdlPipe[ADD_LAT-1];

    // Record every result strobe shortly after the edge that raised it.
    always @(posedge iCLK) begin
        #1;
        if (bus.oRES_VALID === 1'b1) begin
            resTagQ.push_back(int'(bus.oRES_TAG));
            resDataQ.push_back(bus.oRES_DATA);
            resCycQ.push_back(cyc);
        end
    end

    task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] a,
                                 input logic [127:0] b, input logic [3:0] add,
                                 input logic flush);
        bus.iREQ_VALID = valid;
        bus.iREQ_A     = a;
        bus.iREQ_B     = b;
        bus.iREQ_ADD   = add;
        bus.iFLUSH     = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearResults();
        resTagQ.delete();
        resDataQ.delete();
        resCycQ.delete();
    endtask

    task automatic waitResults(input int n, input int budget);
        int left = budget;
        while (resTagQ.size() < n && left > 0) begin
            @(negedge iCLK);
            left--;
        end
    endtask

    task automatic getResult(input int idx, output int tag, output fp32_t data, output int c);
        if (idx < resTagQ.size()) begin
            tag  = resTagQ[idx];
            data = resDataQ[idx];
            c    = resCycQ[idx];
        end else begin
            tag  = -1;
            data = 32'hFFFFFFFF;
            c    = -1;
        end
    endtask

    task automatic doReset();
        @(negedge iCLK);
        iRST_N = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    initial begin
        exp2[0] = 32'h40400000;
        exp2[1] = 32'h40800000;
        exp2[2] = 32'h40000000;
        exp2[3] = 32'h40C00000;

        // Reset values, with every requester valid to show READY stays low.
        applyStimulus(4'b1111, '1, '1, 4'b1111, 1'b0);
        repeat (2) @(negedge iCLK);
        #1;
        checkOutput("rstReady",  32'(bus.oREQ_READY),  32'h0);
        checkOutput("rstAddA",   bus.oADD_A,           32'h0);
        checkOutput("rstAddB",   bus.oADD_B,           32'h0);
        checkOutput("rstAddSub", 32'(bus.oADD_ADDSUB), 32'h1);
        checkOutput("rstResVal", 32'(bus.oRES_VALID),  32'h0);
        checkOutput("rstResTag", 32'(bus.oRES_TAG),    32'h0);
        checkOutput("rstResDat", bus.oRES_DATA,        32'h0);
        checkOutput("rstIdle",   32'(bus.oIDLE),       32'h1);
        applyStimulus('0, '0, '0, '0, 1'b0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Test 1: requester 0 alone, 1.0 + 2.0.
        $display("[TB] test 1: single add from requester 0");
        clearResults();
        applyStimulus(4'b0001, {96'h0, FP_ONE}, {96'h0, FP_TWO}, 4'b0001, 1'b0);
        #1;
        checkOutput("t1Ready", 32'(bus.oREQ_READY), 32'h1);
        checkOutput("t1IdleBusy", 32'(bus.oIDLE), 32'h0);
        @(negedge iCLK);
        issueCyc = cyc;
        applyStimulus('0, '0, '0, '0, 1'b0);
        checkOutput("t1AddA", bus.oADD_A, FP_ONE);
        checkOutput("t1AddB", bus.oADD_B, FP_TWO);
        checkOutput("t1AddSub", 32'(bus.oADD_ADDSUB), 32'h1);
        waitResults(1, 20);
        repeat (3) @(negedge iCLK);
        checkOutput("t1Count", resTagQ.size(), 1);
        getResult(0, rTag, rData, rCyc);
        checkOutput("t1Tag", rTag, 0);
        checkOutput("t1Data", rData, 32'h40400000);
        checkOutput("t1Latency", rCyc - issueCyc, ADD_LAT + 1);

        // Test 2: all four valid for 8 cycles from a fresh pointer.
        $display("[TB] test 2: round-robin stream");
        doReset();
        clearResults();
        applyStimulus(4'b1111, {FP_THREE, FP_THREE, FP_TWO, FP_ONE},
                      {FP_THREE, FP_ONE, FP_TWO, FP_TWO}, 4'b1011, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("t2Ready%0d", i), 32'(bus.oREQ_READY), 32'(1) << (i % 4));
            @(negedge iCLK);
            if (i == 0) issueCyc = cyc;
        end
        applyStimulus('0, '0, '0, '0, 1'b0);
        waitResults(8, 30);
        checkOutput("t2Count", resTagQ.size(), 8);
        for (int i = 0; i < 8; i++) begin
            getResult(i, rTag, rData, rCyc);
            checkOutput($sformatf("t2Tag%0d", i), rTag, i % 4);
            checkOutput($sformatf("t2Data%0d", i), rData, exp2[i % 4]);
            checkOutput($sformatf("t2Cyc%0d", i), rCyc, issueCyc + ADD_LAT + 1 + i);
        end

        // Test 3: requester 2 subtracts 2.0 - 1.0.
        $display("[TB] test 3: subtract from requester 2");
        clearResults();
        applyStimulus(4'b0100, {32'h0, FP_TWO, 64'h0}, {32'h0, FP_ONE, 64'h0}, 4'b0000, 1'b0);
        #1;
        checkOutput("t3Ready", 32'(bus.oREQ_READY), 32'h4);
        @(negedge iCLK);
        issueCyc = cyc;
        applyStimulus('0, '0, '0, '0, 1'b0);
        checkOutput("t3AddSub", 32'(bus.oADD_ADDSUB), 32'h0);
        checkOutput("t3AddA", bus.oADD_A, FP_TWO);
        waitResults(1, 20);
        getResult(0, rTag, rData, rCyc);
        checkOutput("t3Tag", rTag, 2);
        checkOutput("t3Data", rData, 32'h3F800000);
        checkOutput("t3Latency", rCyc - issueCyc, ADD_LAT + 1);

        // Test 4: three issues (pointer now at 3), then flush with all valid.
        $display("[TB] test 4: flush drain");
        clearResults();
        applyStimulus(4'b1111, {FP_THREE, FP_THREE, FP_TWO, FP_ONE},
                      {FP_THREE, FP_ONE, FP_TWO, FP_TWO}, 4'b1011, 1'b0);
        #1;
        checkOutput("t4Ready0", 32'(bus.oREQ_READY), 32'h8);
        @(negedge iCLK);
        #1;
        checkOutput("t4Ready1", 32'(bus.oREQ_READY), 32'h1);
        @(negedge iCLK);
        #1;
        checkOutput("t4Ready2", 32'(bus.oREQ_READY), 32'h2);
        @(negedge iCLK);
        bus.iFLUSH = 1'b1;
        #1;
        for (int k = 0; k < 30 && resTagQ.size() < 3; k++) begin
            checkOutput("t4ReadyFlush", 32'(bus.oREQ_READY), 32'h0);
            checkOutput("t4IdleBusy", 32'(bus.oIDLE), 32'h0);
            @(negedge iCLK);
            #1;
        end
        checkOutput("t4Count", resTagQ.size(), 3);
        checkOutput("t4IdleDone", 32'(bus.oIDLE), 32'h1);
        checkOutput("t4ReadyEnd", 32'(bus.oREQ_READY), 32'h0);
        getResult(0, rTag, rData, rCyc);
        checkOutput("t4Tag0", rTag, 3);
        checkOutput("t4Data0", rData, exp2[3]);
        getResult(1, rTag, rData, rCyc);
        checkOutput("t4Tag1", rTag, 0);
        checkOutput("t4Data1", rData, exp2[0]);
        getResult(2, rTag, rData, rCyc);
        checkOutput("t4Tag2", rTag, 1);
        checkOutput("t4Data2", rData, exp2[1]);
        @(negedge iCLK);
        applyStimulus('0, '0, '0, '0, 1'b0);

        // Test 5: two ops in flight, then asynchronous reset mid-cycle.
        $display("[TB] test 5: reset with ops in flight");
        clearResults();
        applyStimulus(4'b0001, {96'h0, FP_ONE}, {96'h0, FP_ONE}, 4'b0001, 1'b0);
        #1;
        checkOutput("t5Ready", 32'(bus.oREQ_READY), 32'h1);
        repeat (2) @(negedge iCLK);
        applyStimulus('0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge iCLK);
        #1;
        checkOutput("t5IdleBusy", 32'(bus.oIDLE), 32'h0);
        #1;
        applyStimulus(4'b0001, {96'h0, FP_ONE}, {96'h0, FP_ONE}, 4'b0001, 1'b0);
        iRST_N = 1'b0;
        #1;
        checkOutput("t5Ready0",   32'(bus.oREQ_READY),  32'h0);
        checkOutput("t5AddA",     bus.oADD_A,           32'h0);
        checkOutput("t5AddB",     bus.oADD_B,           32'h0);
        checkOutput("t5AddSub",   32'(bus.oADD_ADDSUB), 32'h1);
        checkOutput("t5ResVal",   32'(bus.oRES_VALID),  32'h0);
        checkOutput("t5ResTag",   32'(bus.oRES_TAG),    32'h0);
        checkOutput("t5ResDat",   bus.oRES_DATA,        32'h0);
        checkOutput("t5IdleRst",  32'(bus.oIDLE),       32'h1);
        repeat (2) @(negedge iCLK);
        applyStimulus('0, '0, '0, '0, 1'b0);
        iRST_N = 1'b1;
        repeat (15) @(negedge iCLK);
        checkOutput("t5NoResult", resTagQ.size(), 0);
        checkOutput("t5IdleAfter", 32'(bus.oIDLE), 32'h1);

        // Test 6: requester 1 streams 20 ops; count settles at ADD_LAT+1.
        $display("[TB] test 6: steady stream");
        clearResults();
        applyStimulus(4'b0010, {64'h0, FP_ONE, 32'h0}, {64'h0, FP_ONE, 32'h0}, 4'b0010, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge iCLK);
            checkOutput($sformatf("t6Inflight%0d", k), 32'(dut.r_inflight),
                        (k + 1 < ADD_LAT + 1) ? k + 1 : ADD_LAT + 1);
        end
        applyStimulus('0, '0, '0, '0, 1'b0);
        waitResults(20, 40);
        checkOutput("t6Count", resTagQ.size(), 20);
        for (int i = 0; i < 20; i++) begin
            getResult(i, rTag, rData, rCyc);
            if (i == 0) firstCyc = rCyc;
            checkOutput($sformatf("t6Tag%0d", i), rTag, 1);
            checkOutput($sformatf("t6Data%0d", i), rData, 32'h40000000);
            checkOutput($sformatf("t6Cyc%0d", i), rCyc - firstCyc, i);
        end
        checkOutput("t6InflightEnd", 32'(dut.r_inflight), 32'h0);
        checkOutput("t6IdleEnd", 32'(bus.oIDLE), 32'h1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
